rx_source_select: RTL and testbench
===================================

Name: rx_source_select

Overview:
- Parametrised successor to the fixed two-channel RX source mux (normal / loopback / debug counter) that feeds rx_buffer_inband.
- Selects, per RX sample strobe, between DDC baseband data, a buffered TX-to-RX loopback path and a generated counter pattern, for NUM_CHAN RX channels.
- Replaces single-register loopback capture with a FIFO that absorbs TX/RX strobe-rate mismatch, plus sticky overrun/underrun flags.
- Sits between the rx_chain outputs and the rx buffer, in the clk64 domain.

Parameters:
- NUM_CHAN, 8, RX channel count (even, 2..8); loopback fills even/odd channel pairs.
- WIDTH, 16, sample width in bits.
- LOOP_DEPTH, 16, loopback FIFO depth in I/Q pairs; power of 2, >= 2.

Ports:
- clock  in  1  DSP clock (clk64).
- reset  in  1  synchronous, active-high.
- enable  in  1  RX enable; low holds the counter and FIFO cleared.
- mode  in  2  00 normal, 01 loopback, 10 counter, 11 ramp-per-channel.
- clear_status  in  1  clears sticky flags.
- tx_strobe  in  1  TX interpolator strobe.
- tx_i  in  WIDTH  TX channel 0 I.
- tx_q  in  WIDTH  TX channel 0 Q.
- rx_strobe  in  1  RX half-band strobe.
- bb_in  in  NUM_CHAN*WIDTH  DDC outputs; channel k at [k*WIDTH +: WIDTH].
- ch_out  out  NUM_CHAN*WIDTH  selected samples, same packing.
- out_strobe  out  1  one-cycle pulse when ch_out updates.
- loop_overrun  out  1  sticky; loopback write dropped because FIFO full.
- loop_underrun  out  1  sticky; loopback read while FIFO empty.
- loop_level  out  $clog2(LOOP_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: ch_out=0, out_strobe=0, both flags=0, loop_level=0, counter=0, FIFO pointers=0.
- Latency: ch_out and out_strobe are registered 1 cycle after rx_strobe. ch_out holds between strobes.
- Mode change: mode is sampled every cycle. A change from the previous cycle flushes the FIFO (level=0) and zeroes the counter in that same cycle. A concurrent strobe in that cycle is processed under the new mode against the flushed state.
- enable low: counter=0, FIFO flushed, out_strobe=0. ch_out holds its value; flags hold.
- Normal (00): on rx_strobe, ch_out = bb_in.
- Loopback (01):
  - On tx_strobe, push {tx_i, tx_q} if not full. If full, drop the pair and set loop_overrun.
  - On rx_strobe, pop one pair to all even channels (I) and odd channels (Q) if not empty.
  - If empty, ch_out holds its previous value, loop_underrun is set, and out_strobe still pulses.
  - Push and pop in the same cycle:
    - full: pop and push both succeed, level unchanged, no overrun.
    - empty: push succeeds, pop underruns. No bypass.
  - Pointers wrap modulo LOOP_DEPTH.
- Counter (10):
  - On rx_strobe, channel k = counter + k.
  - Counter then advances by NUM_CHAN, using WIDTH-bit wrapping arithmetic.
- Ramp (11):
  - On rx_strobe, channel k = {k[2:0], counter[WIDTH-4:0]}; the top 3 bits tag the channel index.
  - Counter then advances by 1 and wraps at 2^(WIDTH-3).
- Flags:
  - clear_status has priority over a set in the same cycle; the flag reads 0 the next cycle.
  - Flags update only in loopback mode.
- Outside loopback mode, tx_strobe is ignored and the FIFO stays empty.
- Reset mid-operation returns all state to reset values on the next edge, regardless of strobes.

Test Plan:
- Counter mode, NUM_CHAN=8: reset, enable=1, 3 rx_strobes → ch_out channels 0..7 = 0..7, then 8..15, then 16..23. out_strobe is one cycle after each strobe.
- Counter wrap, WIDTH=16: preload by strobing to 0xFFF8 → next ch0=0xFFF8, ch7=0xFFFF; the following strobe gives ch0=0x0000.
- Loopback FIFO: push 5 pairs (0x1000+n, 0x2000+n), then 5 rx_strobes → even channels 0x1000..0x1004 and odd channels 0x2000..0x2004, in order. The 6th strobe holds 0x1004/0x2004 and sets loop_underrun.
- Overflow, LOOP_DEPTH=16: 17 tx_strobes with no rx → level=16, loop_overrun=1, 17th pair absent. Then tx_strobe and rx_strobe in the same cycle → level stays 16, no new overrun. clear_status → flag reads 0 the next cycle.
- Mode switch mid-stream: with 4 pairs queued, switch to normal then back to loopback → level=0. The first rx_strobe underruns.
- Reset during loopback with level=7 and rx_strobe asserted → next cycle ch_out=0, out_strobe=0, level=0, flags=0.

Source files
------------

// File: rtl/rx_source_select_if.sv
`default_nettype none
// ============================================================================
// rx_source_select_if : sample/strobe bundle between the TX/RX chains and the
//                       RX source mux.  Rev 1.0
// ============================================================================
interface rx_source_select_if #(
  parameter int NUM_CHAN = 8,
  parameter int WIDTH    = 16
) ();
  logic                      tx_strobe;
  logic [WIDTH-1:0]          tx_i;
  logic [WIDTH-1:0]          tx_q;
  logic                      rx_strobe;
  logic [NUM_CHAN*WIDTH-1:0] bb_in;
  logic [NUM_CHAN*WIDTH-1:0] ch_out;
  logic                      out_strobe;

  modport master (
    output tx_strobe, tx_i, tx_q, rx_strobe, bb_in,
    input  ch_out, out_strobe
  );

  modport slave (
    input  tx_strobe, tx_i, tx_q, rx_strobe, bb_in,
    output ch_out, out_strobe
  );
endinterface
`default_nettype wire

// File: rtl/rx_source_select.sv
`default_nettype none
// ============================================================================
// rx_source_select : per-strobe RX source mux (DDC / TX loopback FIFO /
//                    counter / per-channel ramp) for NUM_CHAN channels.  Rev 1.0
// ============================================================================
module rx_source_select #(
  parameter int NUM_CHAN   = 8,
  parameter int WIDTH      = 16,
  parameter int LOOP_DEPTH = 16
) (
  input  wire                          clock,
  input  wire                          reset,
  input  wire                          enable,
  input  wire  [1:0]                   mode,
  input  wire                          clear_status,
  rx_source_select_if.slave            bus,
  output logic                         loop_overrun,
  output logic                         loop_underrun,
  output logic [$clog2(LOOP_DEPTH):0]  loop_level
);

  localparam int AW = $clog2(LOOP_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_LOOP   = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;
  localparam logic [1:0] MODE_RAMP   = 2'b11;

  logic [1:0]                mode_prev_q;
  logic [WIDTH-1:0]          cnt_q,      cnt_d;
  logic [AW-1:0]             wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0]             level_q,    level_d;
  logic [NUM_CHAN*WIDTH-1:0] ch_q,       ch_d;
  logic                      out_strobe_q, out_strobe_d;
  logic                      overrun_q,  overrun_d;
  logic                      underrun_q, underrun_d;
  logic [2*WIDTH-1:0]        mem_q [LOOP_DEPTH];

  logic                      mode_change;
  logic                      loop_active;
  logic [WIDTH-1:0]          cnt_base;
  logic [WIDTH-4:0]          ramp_next;
  logic [AW-1:0]             wr_base;
  logic [AW-1:0]             rd_base;
  logic [LW-1:0]             level_base;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      push_ok;
  logic                      pop_ok;
  logic [2*WIDTH-1:0]        pop_data;

  always_comb begin
    mode_change = (mode != mode_prev_q);
    loop_active = enable && (mode == MODE_LOOP);

    // A mode change or disable acts as a flush within the same cycle, so any
    // concurrent strobe sees a zero counter and an empty FIFO.
    cnt_base   = (mode_change || !enable) ? '0 : cnt_q;
    wr_base    = (loop_active && !mode_change) ? wr_ptr_q : '0;
    rd_base    = (loop_active && !mode_change) ? rd_ptr_q : '0;
    level_base = (loop_active && !mode_change) ? level_q  : '0;

    fifo_empty = (level_base == '0);
    fifo_full  = (level_base == LW'(LOOP_DEPTH));
    pop_ok     = loop_active && bus.rx_strobe && !fifo_empty;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    push_ok    = loop_active && bus.tx_strobe && (!fifo_full || pop_ok);
    pop_data   = mem_q[rd_base];

    wr_ptr_d   = wr_base + (push_ok ? AW'(1) : AW'(0));
    rd_ptr_d   = rd_base + (pop_ok  ? AW'(1) : AW'(0));
    level_d    = level_base + (push_ok ? LW'(1) : LW'(0)) - (pop_ok ? LW'(1) : LW'(0));

    ramp_next    = cnt_base[WIDTH-4:0] + (WIDTH-3)'(1);
    cnt_d        = cnt_base;
    ch_d         = ch_q;
    out_strobe_d = enable && bus.rx_strobe;

    if (enable && bus.rx_strobe) begin
      case (mode)
        MODE_NORMAL: ch_d = bus.bb_in;
        MODE_LOOP: begin
          if (pop_ok) begin
            for (int k = 0; k < NUM_CHAN; k++) begin
              ch_d[k*WIDTH +: WIDTH] = (k % 2 == 0) ? pop_data[2*WIDTH-1:WIDTH]
                                                    : pop_data[WIDTH-1:0];
            end
          end
        end
        MODE_COUNT: begin
          for (int k = 0; k < NUM_CHAN; k++) begin
            ch_d[k*WIDTH +: WIDTH] = cnt_base + WIDTH'(k);
          end
          cnt_d = cnt_base + WIDTH'(NUM_CHAN);
        end
        MODE_RAMP: begin
          for (int k = 0; k < NUM_CHAN; k++) begin
            ch_d[k*WIDTH +: WIDTH] = {3'(k), cnt_base[WIDTH-4:0]};
          end
          cnt_d = {3'b000, ramp_next};
        end
        default: ch_d = ch_q;
      endcase
    end

    overrun_d  = overrun_q  || (loop_active && bus.tx_strobe && !push_ok);
    underrun_d = underrun_q || (loop_active && bus.rx_strobe && fifo_empty);
    if (clear_status) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_prev_q  <= MODE_NORMAL;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ch_q         <= '0;
      out_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      mode_prev_q  <= mode;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ch_q         <= ch_d;
      out_strobe_q <= out_strobe_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem_q[wr_base] <= {bus.tx_i, bus.tx_q};
    end
  end

  assign bus.ch_out     = ch_q;
  assign bus.out_strobe = out_strobe_q;
  assign loop_overrun   = overrun_q;
  assign loop_underrun  = underrun_q;
  assign loop_level     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_source_select.sv
`default_nettype none
// ============================================================================
// tb_rx_source_select : directed plus randomized bench for rx_source_select,
//                       checked against a queue-based reference model.  Rev 1.0
// ============================================================================
module tb_rx_source_select;

  localparam int NUM_CHAN   = 8;
  localparam int WIDTH      = 16;
  localparam int LOOP_DEPTH = 16;
  localparam int LW         = $clog2(LOOP_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic          clear_status;
  logic          loop_overrun;
  logic          loop_underrun;
  logic [LW-1:0] loop_level;

  rx_source_select_if #(.NUM_CHAN(NUM_CHAN), .WIDTH(WIDTH)) bus ();

  rx_source_select #(
    .NUM_CHAN   (NUM_CHAN),
    .WIDTH      (WIDTH),
    .LOOP_DEPTH (LOOP_DEPTH)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .enable        (enable),
    .mode          (mode),
    .clear_status  (clear_status),
    .bus           (bus),
    .loop_overrun  (loop_overrun),
    .loop_underrun (loop_underrun),
    .loop_level    (loop_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain queue FIFO and integer counter.
  logic [1:0]                m_prev;
  int                        m_cnt;
  logic [2*WIDTH-1:0]        m_fifo[$];
  logic [NUM_CHAN*WIDTH-1:0] m_ch;
  logic                      m_os, m_ov, m_un;

  task automatic model_step();
    logic set_ov, set_un;
    logic [2*WIDTH-1:0] d;
    set_ov = 1'b0;
    set_un = 1'b0;
    if (rst) begin
      m_prev = 2'b00; m_cnt = 0; m_fifo.delete();
      m_ch = '0; m_os = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      return;
    end
    if (mode != m_prev || !enable) begin
      m_cnt = 0;
      m_fifo.delete();
    end
    m_prev = mode;
    if (mode != 2'b01) m_fifo.delete();
    m_os = enable && bus.rx_strobe;
    if (enable) begin
      case (mode)
        2'b00: if (bus.rx_strobe) m_ch = bus.bb_in;
        2'b01: begin
          if (bus.rx_strobe) begin
            if (m_fifo.size() > 0) begin
              d = m_fifo.pop_front();
              for (int k = 0; k < NUM_CHAN; k++)
                m_ch[k*WIDTH +: WIDTH] = (k % 2 == 0) ? d[2*WIDTH-1:WIDTH] : d[WIDTH-1:0];
            end else set_un = 1'b1;
          end
          if (bus.tx_strobe) begin
            if (m_fifo.size() < LOOP_DEPTH) m_fifo.push_back({bus.tx_i, bus.tx_q});
            else set_ov = 1'b1;
          end
        end
        2'b10: if (bus.rx_strobe) begin
          for (int k = 0; k < NUM_CHAN; k++)
            m_ch[k*WIDTH +: WIDTH] = WIDTH'((m_cnt + k) % (1 << WIDTH));
          m_cnt = (m_cnt + NUM_CHAN) % (1 << WIDTH);
        end
        default: if (bus.rx_strobe) begin
          for (int k = 0; k < NUM_CHAN; k++)
            m_ch[k*WIDTH +: WIDTH] = WIDTH'(((k % 8) << (WIDTH-3)) + (m_cnt % (1 << (WIDTH-3))));
          m_cnt = (m_cnt + 1) % (1 << (WIDTH-3));
        end
      endcase
    end
    if (clear_status) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (enable && mode == 2'b01) begin
      m_ov = m_ov | set_ov;
      m_un = m_un | set_un;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("ch_out",     bus.ch_out,     m_ch);
    check("out_strobe", bus.out_strobe, m_os);
    check("overrun",    loop_overrun,   m_ov);
    check("underrun",   loop_underrun,  m_un);
    check("level",      loop_level,     m_fifo.size());
  endtask

  function automatic logic [WIDTH-1:0] ch(input int k);
    return bus.ch_out[k*WIDTH +: WIDTH];
  endfunction

  int tx_rate, rx_rate;

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00; clear_status = 1'b0;
    bus.tx_strobe = 1'b0; bus.tx_i = '0; bus.tx_q = '0;
    bus.rx_strobe = 1'b0; bus.bb_in = '0;
    m_prev = 2'b00; m_cnt = 0; m_ch = '0; m_os = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    tick(); tick();
    check("rst_level", loop_level, 0);
    check("rst_ch", bus.ch_out, 0);

    // Counter mode
    rst = 1'b0; enable = 1'b1; mode = 2'b10;
    tick();
    for (int s = 0; s < 3; s++) begin
      bus.rx_strobe = 1'b1; tick();
      check("cnt_ch0", ch(0), 8*s);
      check("cnt_ch7", ch(7), 8*s + 7);
      check("cnt_os_hi", bus.out_strobe, 1);
      bus.rx_strobe = 1'b0; tick();
      check("cnt_os_lo", bus.out_strobe, 0);
    end

    // Walk the counter up to 0xFFF8 and across the wrap
    bus.rx_strobe = 1'b1;
    repeat (8188) tick();
    tick();
    check("wrap_ch0", ch(0), 16'hFFF8);
    check("wrap_ch7", ch(7), 16'hFFFF);
    tick();
    check("wrap_next_ch0", ch(0), 16'h0000);
    bus.rx_strobe = 1'b0; tick();

    // Loopback ordering and underrun hold
    mode = 2'b01; tick();
    bus.tx_strobe = 1'b1;
    for (int n = 0; n < 5; n++) begin
      bus.tx_i = WIDTH'(16'h1000 + n); bus.tx_q = WIDTH'(16'h2000 + n); tick();
    end
    bus.tx_strobe = 1'b0;
    check("lb_level5", loop_level, 5);
    for (int n = 0; n < 5; n++) begin
      bus.rx_strobe = 1'b1; tick();
      check("lb_even", ch(0), 16'h1000 + n);
      check("lb_odd",  ch(7), 16'h2000 + n);
    end
    tick();
    check("lb_hold_i", ch(6), 16'h1004);
    check("lb_hold_q", ch(1), 16'h2004);
    check("lb_underrun", loop_underrun, 1);
    check("lb_under_os", bus.out_strobe, 1);
    bus.rx_strobe = 1'b0;

    // Overflow
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    bus.tx_strobe = 1'b1;
    for (int n = 0; n < 17; n++) begin
      bus.tx_i = WIDTH'(16'h3000 + n); bus.tx_q = WIDTH'(16'h4000 + n); tick();
    end
    bus.tx_strobe = 1'b0;
    check("ovf_level", loop_level, 16);
    check("ovf_flag", loop_overrun, 1);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    check("ovf_cleared", loop_overrun, 0);
    bus.tx_strobe = 1'b1; bus.rx_strobe = 1'b1;
    bus.tx_i = 16'h5000; bus.tx_q = 16'h6000; tick();
    bus.tx_strobe = 1'b0;
    check("full_pp_level", loop_level, 16);
    check("full_pp_ovf", loop_overrun, 0);
    check("full_pp_data", ch(0), 16'h3000);
    repeat (16) tick();
    check("ovf_17th_absent", ch(0), 16'h5000);
    check("drain_level", loop_level, 0);
    bus.rx_strobe = 1'b0;

    // Mode switch flushes the FIFO
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    bus.tx_strobe = 1'b1;
    for (int n = 0; n < 4; n++) begin
      bus.tx_i = WIDTH'(16'h7000 + n); bus.tx_q = WIDTH'(16'h7100 + n); tick();
    end
    bus.tx_strobe = 1'b0;
    check("ms_level4", loop_level, 4);
    mode = 2'b00; tick();
    mode = 2'b01; tick();
    check("ms_flushed", loop_level, 0);
    bus.rx_strobe = 1'b1; tick(); bus.rx_strobe = 1'b0;
    check("ms_underrun", loop_underrun, 1);

    // Reset mid-loopback with a strobe pending
    bus.tx_strobe = 1'b1;
    for (int n = 0; n < 7; n++) begin
      bus.tx_i = WIDTH'(16'h0A00 + n); bus.tx_q = WIDTH'(16'h0B00 + n); tick();
    end
    bus.tx_strobe = 1'b0;
    check("rst_pre_level", loop_level, 7);
    bus.rx_strobe = 1'b1; rst = 1'b1; tick();
    check("rstm_ch", bus.ch_out, 0);
    check("rstm_os", bus.out_strobe, 0);
    check("rstm_level", loop_level, 0);
    check("rstm_flags", {loop_overrun, loop_underrun}, 0);
    rst = 1'b0; bus.rx_strobe = 1'b0; tick();

    // Randomized traffic
    tx_rate = 2; rx_rate = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        tx_rate = $urandom_range(1, 4);
        rx_rate = $urandom_range(1, 4);
      end
      rst          = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      enable       = ($urandom_range(0, 24) != 0);
      clear_status = ($urandom_range(0, 39) == 0);
      bus.tx_strobe = ($urandom_range(1, tx_rate) == 1);
      bus.rx_strobe = ($urandom_range(1, rx_rate) == 1);
      bus.tx_i  = WIDTH'($urandom);
      bus.tx_q  = WIDTH'($urandom);
      bus.bb_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
